// File: rtl/timer_irq_source.sv
// rtl/timer_irq_source.sv - memory-mapped reload timer driving the CPU IRQ line
//
// Purpose: prescaled 32-bit up-counter (TL) that reloads from TH on overflow
// and raises a sticky, software-cleared interrupt to the control unit.
//
// Register window (word offsets from BASE_ADDR):
//   +0x0 TH      reload value, read/write
//   +0x4 TL      counter, read/write
//   +0x8 TCON    [0] run, [1] irq_en, [2] irq_status; [31:3] read 0
//   +0xC SYSTICK free-running cycle counter, read-only (only with TIMER_SYSTICK_EN)
//
// Optional feature macro: TIMER_SYSTICK_EN
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   MemRd      bus read strobe
//   MemWr      bus write strobe
//   Addr       byte address, exact word match decoded
//   WriteData  bus write data
//   ReadData   combinational read data, 0 when unselected or MemRd=0
//   IRQ        registered interrupt request

module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    logic [31:0] th;
    logic [31:0] tl;
    logic        run;
    logic        irq_en;
    logic        irq_status;
    logic [15:0] pcnt;

    logic hit_th, hit_tl, hit_tcon;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf, ovf_set;

    assign hit_th   = (Addr == BASE_ADDR);
    assign hit_tl   = (Addr == BASE_ADDR + 32'h4);
    assign hit_tcon = (Addr == BASE_ADDR + 32'h8);

    assign wr_th   = MemWr && hit_th;
    assign wr_tl   = MemWr && hit_tl;
    assign wr_tcon = MemWr && hit_tcon;

    assign tick    = run && (pcnt == PCNT_LAST);
    assign ovf     = tick && (tl == 32'hFFFF_FFFF);
    // Status is only latched when the interrupt is enabled at overflow time.
    assign ovf_set = ovf && irq_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th         <= 32'h0;
            tl         <= 32'h0;
            run        <= 1'b0;
            irq_en     <= 1'b0;
            irq_status <= 1'b0;
            pcnt       <= 16'h0;
            IRQ        <= 1'b0;
        end else begin
            if (wr_th) begin
                th <= WriteData;
            end

            // Bus write beats the count; reload uses the TH held before this edge.
            if (wr_tl) begin
                tl <= WriteData;
            end else if (tick) begin
                tl <= ovf ? th : tl + 32'h1;
            end

            // An overflow in the same cycle as a software clear keeps status set
            // so no interrupt is lost.
            if (wr_tcon) begin
                run        <= WriteData[0];
                irq_en     <= WriteData[1];
                irq_status <= WriteData[2] | ovf_set;
            end else if (ovf_set) begin
                irq_status <= 1'b1;
            end

            if (wr_tcon && !WriteData[0]) begin
                pcnt <= 16'h0;
            end else if (run) begin
                pcnt <= tick ? 16'h0 : pcnt + 16'h1;
            end

            IRQ <= irq_status & irq_en;
        end
    end

`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick;
    logic        hit_systick;

    assign hit_systick = (Addr == BASE_ADDR + 32'hC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= 32'h0;
        end else begin
            systick <= systick + 32'h1;
        end
    end
`endif

    always_comb begin
        ReadData = 32'h0;
        if (MemRd) begin
            if (hit_th) begin
                ReadData = th;
            end else if (hit_tl) begin
                ReadData = tl;
            end else if (hit_tcon) begin
                ReadData = {29'h0, irq_status, irq_en, run};
            end
`ifdef TIMER_SYSTICK_EN
            else if (hit_systick) begin
                ReadData = systick;
            end
`endif
        end
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// tb/tb_timer_irq_source.sv - directed self-checking bench for timer_irq_source

module tb_timer_irq_source;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'h4;
    localparam logic [31:0] A_TC = BASE + 32'h8;
    localparam logic [31:0] A_ST = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRd = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        wr1 = 1'b0;
    logic        wr4 = 1'b0;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(wr1), .Addr(Addr),
        .WriteData(WriteData), .ReadData(rd1), .IRQ(irq1)
    );

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(wr4), .Addr(Addr),
        .WriteData(WriteData), .ReadData(rd4), .IRQ(irq4)
    );

    // Commits on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input int which, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        WriteData = d;
        if (which == 4) wr4 = 1'b1; else wr1 = 1'b1;
        @(posedge clk);
        #1;
        wr1 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic bus_read(input int which, input logic [31:0] a, output logic [31:0] v);
        Addr = a;
        MemRd = 1'b1;
        #1;
        v = (which == 4) ? rd4 : rd1;
        MemRd = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #2;
        bus_read(1, A_TH, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_th got=%h exp=%h", v, 32'h0); end
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tl got=%h exp=%h", v, 32'h0); end
        bus_read(1, A_TC, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tcon got=%h exp=%h", v, 32'h0); end
        n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq1); end
        @(negedge clk);
        reset = 1'b1;
        bus_write(1, A_TC, 32'hFFFF_FFF8);
        bus_read(1, A_TC, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL tcon_upper got=%h exp=%h", v, 32'h0); end
    endtask

    task automatic test_overflow_reload();
        logic [31:0] v;
        bus_write(1, A_TH, 32'hFFFF_FFFD);
        bus_write(1, A_TL, 32'hFFFF_FFFE);
        bus_write(1, A_TC, 32'h3);
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL ovf_start got=%h exp=%h", v, 32'hFFFF_FFFE); end
        step();
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ovf_tick1 got=%h exp=%h", v, 32'hFFFF_FFFF); end
        step();
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL ovf_reload got=%h exp=%h", v, 32'hFFFF_FFFD); end
        bus_read(1, A_TC, v);
        n_tests++; if (v !== 32'h7) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", v, 32'h7); end
        n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_early got=%b exp=0", irq1); end
        step();
        n_tests++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got=%b exp=1", irq1); end
    endtask

    task automatic test_clear_set_race();
        logic [31:0] v;
        // TL is FFFF_FFFE here; the edge after the next one is an overflow.
        step();
        bus_write(1, A_TC, 32'h3);
        bus_read(1, A_TC, v);
        n_tests++; if (v !== 32'h7) begin n_fail++; $display("FAIL race_tcon got=%h exp=%h", v, 32'h7); end
        n_tests++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL race_irq got=%b exp=1", irq1); end
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL race_tl got=%h exp=%h", v, 32'hFFFF_FFFD); end
        // Plain clear with no overflow: status drops, IRQ follows one edge later.
        bus_write(1, A_TC, 32'h3);
        bus_read(1, A_TC, v);
        n_tests++; if (v !== 32'h3) begin n_fail++; $display("FAIL clear_tcon got=%h exp=%h", v, 32'h3); end
        step();
        n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL clear_irq got=%b exp=0", irq1); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        repeat (3) step();
        bus_write(1, A_TL, 32'h5);
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'h5) begin n_fail++; $display("FAIL mid_tl_pre got=%h exp=%h", v, 32'h5); end
        n_tests++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pre got=%b exp=1", irq1); end
        reset = 1'b0;
        #1;
        n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL mid_irq got=%b exp=0", irq1); end
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_tl got=%h exp=%h", v, 32'h0); end
        bus_read(1, A_TH, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_th got=%h exp=%h", v, 32'h0); end
        bus_read(1, A_TC, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL mid_tcon got=%h exp=%h", v, 32'h0); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        logic [31:0] exp_tl [1:8];
        exp_tl = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1, 32'h2};
        bus_write(4, A_TC, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            step();
            bus_read(4, A_TL, v);
            n_tests++; if (v !== exp_tl[i]) begin n_fail++; $display("FAIL presc_edge%0d got=%h exp=%h", i, v, exp_tl[i]); end
        end
        bus_write(4, A_TC, 32'h0);
        repeat (10) step();
        bus_read(4, A_TL, v);
        n_tests++; if (v !== 32'h2) begin n_fail++; $display("FAIL presc_hold got=%h exp=%h", v, 32'h2); end
        // Prescaler was cleared by run=0, so a full 4 edges are needed again.
        bus_write(4, A_TC, 32'h1);
        repeat (3) step();
        bus_read(4, A_TL, v);
        n_tests++; if (v !== 32'h2) begin n_fail++; $display("FAIL presc_restart3 got=%h exp=%h", v, 32'h2); end
        step();
        bus_read(4, A_TL, v);
        n_tests++; if (v !== 32'h3) begin n_fail++; $display("FAIL presc_restart4 got=%h exp=%h", v, 32'h3); end
    endtask

    task automatic test_bus_priority();
        logic [31:0] v;
        bus_write(1, A_TC, 32'h1);
        repeat (2) step();
        bus_write(1, A_TL, 32'h10);
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'h10) begin n_fail++; $display("FAIL prio_tl got=%h exp=%h", v, 32'h10); end
        step();
        bus_read(1, A_TL, v);
        n_tests++; if (v !== 32'h11) begin n_fail++; $display("FAIL prio_next got=%h exp=%h", v, 32'h11); end
        bus_write(1, BASE + 32'h10, 32'hDEAD_BEEF);
        bus_read(1, BASE + 32'h10, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped got=%h exp=%h", v, 32'h0); end
        bus_read(1, A_TH, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_th got=%h exp=%h", v, 32'h0); end
        // Read and write together: read sees the value before the write lands.
        bus_write(1, A_TH, 32'h1234_5678);
        @(negedge clk);
        Addr = A_TH;
        WriteData = 32'hCAFE_0001;
        wr1 = 1'b1;
        MemRd = 1'b1;
        #1;
        v = rd1;
        n_tests++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL rdwr_pre got=%h exp=%h", v, 32'h1234_5678); end
        @(posedge clk);
        #1;
        wr1 = 1'b0;
        v = rd1;
        MemRd = 1'b0;
        n_tests++; if (v !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rdwr_post got=%h exp=%h", v, 32'hCAFE_0001); end
    endtask

    task automatic test_systick();
        logic [31:0] v;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) step();
`ifdef TIMER_SYSTICK_EN
        bus_read(1, A_ST, v);
        n_tests++; if (v !== 32'd100) begin n_fail++; $display("FAIL systick got=%0d exp=100", v); end
        bus_write(1, A_ST, 32'h0);
        bus_read(1, A_ST, v);
        n_tests++; if (v !== 32'd101) begin n_fail++; $display("FAIL systick_wr got=%0d exp=101", v); end
`else
        bus_read(1, A_ST, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL off_c got=%h exp=%h", v, 32'h0); end
        bus_write(1, A_ST, 32'hFFFF_FFFF);
        bus_read(1, A_ST, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL off_c_wr got=%h exp=%h", v, 32'h0); end
`endif
    endtask

    initial begin
        test_reset();
        test_overflow_reload();
        test_clear_set_race();
        test_reset_midcount();
        test_prescale();
        test_bus_priority();
        test_systick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
